// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared levels, zero word and clear-sequencer state encoding
package register_file_pkg;

  localparam logic READ_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic RESET_ENABLE  = 1'b1;
  localparam logic RESET_DISABLE = 1'b0;

  // Cast to the user's DATA_WIDTH at the point of use; zero-extension keeps any width valid.
  localparam logic [63:0] ZERO_WORD = 64'h0;

  localparam logic [0:0] STATE_CLEAR = 1'b0;
  localparam logic [0:0] STATE_READY = 1'b1;

endpackage

// File: rtl/register_file_clear_fsm.sv
// rtl/register_file_clear_fsm.sv - CLEAR/READY sequencer that walks entries 1..DEPTH-1 to zero
module register_file_clear_fsm
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  ready,
  output logic                  clear_active,
  output logic [ADDR_WIDTH-1:0] clear_address
);

  localparam logic [ADDR_WIDTH-1:0] FIRST_ENTRY = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY  = {ADDR_WIDTH{1'b1}};

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] pointer;

  // Reset or clear restarts the walk at entry 1; otherwise step the pointer until the last entry is done.
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE || clear) begin
      state   <= STATE_CLEAR;
      pointer <= FIRST_ENTRY;
      ready   <= 1'b0;
    end else if (state == STATE_CLEAR) begin
      pointer <= pointer + ADDR_WIDTH'(1);
      if (pointer == LAST_ENTRY) begin
        state <= STATE_READY;
        ready <= 1'b1;
      end
    end
  end

  assign clear_active  = (state == STATE_CLEAR);
  assign clear_address = pointer;

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - multi-port register file, r0 hardwired to zero; REGISTER_FILE_BYPASS_EN adds write-to-read bypass
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              clear,
  output logic                              ready,
  input  logic [READ_PORTS-1:0]             read_enable,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0]  read_address,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  read_data,
  input  logic [WRITE_PORTS-1:0]            write_enable,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_address,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] write_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ZERO = DATA_WIDTH'(ZERO_WORD);

  logic [DATA_WIDTH-1:0] storage [DEPTH];

  logic                  clear_active;
  logic [ADDR_WIDTH-1:0] clear_address;
  logic                  clear_write;
  logic                  accept;

  logic [WRITE_PORTS-1:0] write_valid;
  logic [ADDR_WIDTH-1:0]  port_address [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]  port_data    [WRITE_PORTS];

  register_file_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .ready         (ready),
    .clear_active  (clear_active),
    .clear_address (clear_address)
  );

  // A reset edge or a fresh clear request must leave storage untouched, so both block the sequencer write.
  assign clear_write = clear_active && (reset == RESET_DISABLE) && !clear;
  assign accept      = ready && (reset == RESET_DISABLE) && !clear;

  for (genvar m = 0; m < WRITE_PORTS; m++) begin : g_write
    assign port_address[m] = write_address[m*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_data[m]    = write_data[m*DATA_WIDTH +: DATA_WIDTH];
    assign write_valid[m]  = accept && (write_enable[m] == WRITE_ENABLE) &&
                             (port_address[m] != '0);
  end

  // Storage update; ports are applied in ascending order so the highest-indexed port wins a conflict.
  always_ff @(posedge clock) begin
    if (clear_write) begin
      storage[clear_address] <= ZERO;
    end else begin
      for (int m = 0; m < WRITE_PORTS; m++) begin
        if (write_valid[m]) begin
          storage[port_address[m]] <= port_data[m];
        end
      end
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] word;

    assign address = read_address[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Combinational read: stored value, optional bypass, then zero gating for reset/clear/disabled/r0.
    always_comb begin
      word = storage[address];
`ifdef REGISTER_FILE_BYPASS_EN
      for (int m = 0; m < WRITE_PORTS; m++) begin
        if (write_valid[m] && port_address[m] == address) begin
          word = port_data[m];
        end
      end
`endif
      if (reset == RESET_ENABLE || clear_active ||
          read_enable[p] != READ_ENABLE || address == '0) begin
        word = ZERO;
      end
    end

    assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = word;
  end

endmodule
